// File: rtl/vmm_pkg.sv
// Shared types and helpers for the row-serial vector-matrix MAC.
//   vmm_state_t      : controller states (IDLE, MAC, STORE, DONE)
//   VMM_DATA_WIDTH   : default element width of A and W
//   VMM_ACCUM_WIDTH  : default accumulator / output element width
//   cnt_width()      : counter width for a given count, never below 1 bit
package vmm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } vmm_state_t;

  localparam int VMM_DATA_WIDTH  = 8;
  localparam int VMM_ACCUM_WIDTH = 32;

  // $clog2(1) is 0, which cannot size a counter, so clamp to one bit.
  function automatic int cnt_width(input int count);
    int w;
    w = $clog2(count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vmm_mac_cell.sv
// One signed multiply-accumulate step, purely combinational.
//   a, w     : signed DATA_WIDTH operands
//   acc_in   : signed ACCUM_WIDTH running sum
//   acc_out  : acc_in + sign-extended full-precision a*w, modulo 2^ACCUM_WIDTH
module vmm_mac_cell #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0]  a,
  input  logic signed [DATA_WIDTH-1:0]  w,
  input  logic signed [ACCUM_WIDTH-1:0] acc_in,
  output logic signed [ACCUM_WIDTH-1:0] acc_out
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACCUM_WIDTH-1:0]  prod_ext;

  assign prod     = a * w;
  // Size cast of a signed value sign-extends.
  assign prod_ext = ACCUM_WIDTH'(prod);
  // Plain wrap-around add; no saturation by design.
  assign acc_out  = acc_in + prod_ext;

endmodule

// File: rtl/vmm_row_serial_mac.sv
// Row-serial vector-matrix multiply: O = A * W, one MAC per cycle.
// Responder on the op_start / op_busy / op_done handshake.
//   clk              : clock, rising edge
//   rst              : synchronous active-high reset
//   op_start         : start request, honoured only in IDLE
//   input_vector_A   : K_DIM signed elements, captured on the start edge
//   weight_matrix_W  : K_DIM x N_DIM signed elements, captured on the start edge
//   output_vector_O  : N_DIM registered results, held until overwritten
//   op_busy          : high in MAC and STORE
//   op_done          : one-cycle pulse in DONE
module vmm_row_serial_mac
  import vmm_pkg::*;
#(
  parameter int DATA_WIDTH  = VMM_DATA_WIDTH,
  parameter int ACCUM_WIDTH = VMM_ACCUM_WIDTH,
  parameter int K_DIM       = 2,
  parameter int N_DIM       = 2
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              op_start,
  input  logic signed [0:K_DIM-1][DATA_WIDTH-1:0]           input_vector_A,
  input  logic signed [0:K_DIM-1][0:N_DIM-1][DATA_WIDTH-1:0] weight_matrix_W,
  output logic signed [0:N_DIM-1][ACCUM_WIDTH-1:0]          output_vector_O,
  output logic                                              op_busy,
  output logic                                              op_done
);

  localparam int KW = cnt_width(K_DIM);
  localparam int NW = cnt_width(N_DIM);
  localparam logic [KW-1:0] K_LAST = KW'(K_DIM - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N_DIM - 1);

  vmm_state_t state, state_nxt;

  logic [KW-1:0] k;
  logic [NW-1:0] n;

  logic [0:K_DIM-1][DATA_WIDTH-1:0]            a_hold;
  logic [0:K_DIM-1][0:N_DIM-1][DATA_WIDTH-1:0] w_hold;

  logic signed [ACCUM_WIDTH-1:0] acc;
  logic signed [ACCUM_WIDTH-1:0] acc_base;
  logic signed [ACCUM_WIDTH-1:0] acc_sum;
  logic signed [DATA_WIDTH-1:0]  mac_a;
  logic signed [DATA_WIDTH-1:0]  mac_w;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_start) state_nxt = MAC;
      MAC:     if (k == K_LAST) state_nxt = STORE;
      STORE:   state_nxt = (n == N_LAST) ? DONE : MAC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign op_busy = (state == MAC) || (state == STORE);
  assign op_done = (state == DONE);

  // Operand capture: only the start edge loads, so later input changes
  // cannot disturb a running operation.
  always_ff @(posedge clk) begin
    if (state == IDLE && op_start) begin
      a_hold <= input_vector_A;
      w_hold <= weight_matrix_W;
    end
  end

  // The first MAC of each column starts from zero, so no separate clear
  // cycle is needed between columns.
  assign mac_a    = a_hold[k];
  assign mac_w    = w_hold[k][n];
  assign acc_base = (k == '0) ? '0 : acc;

  vmm_mac_cell #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACCUM_WIDTH(ACCUM_WIDTH)
  ) u_mac (
    .a      (mac_a),
    .w      (mac_w),
    .acc_in (acc_base),
    .acc_out(acc_sum)
  );

  // Counters, accumulator and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      k               <= '0;
      n               <= '0;
      acc             <= '0;
      output_vector_O <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_start) begin
            k <= '0;
            n <= '0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          k   <= (k == K_LAST) ? '0 : k + 1'b1;
        end
        STORE: begin
          output_vector_O[n] <= acc;
          n                  <= (n == N_LAST) ? '0 : n + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
